// File: rtl/regfile_pkg.sv
// Shared widths and request types for the two-bank register file with scoreboard.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic          fmode;
    logic [AW-1:0] idx;
  } reg_id_t;

  typedef struct packed {
    logic            en;
    reg_id_t         id;
    logic [XLEN-1:0] data;
  } wr_req_t;

  // Integer r0 never stores, forwards or goes busy.
  function automatic logic is_zero_reg(reg_id_t id);
    return !id.fmode && (id.idx == '0);
  endfunction
endpackage

// File: rtl/regfile_bank.sv
// One register bank: synchronous-reset storage, prioritised write ports, raw read ports.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter logic BANK    = 1'b0,
  parameter bit   ZERO_R0 = 1'b0,
  parameter int   NWR     = 2,
  parameter int   NRD     = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  wr_req_t [NWR-1:0]             wr,
  input  logic    [NRD-1:0][AW-1:0]     rd_idx,
  output logic    [NRD-1:0][XLEN-1:0]   rd_data
);
  logic [XLEN-1:0] mem [NREG];

  // Ports applied in ascending order so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wr[k].en && wr[k].id.fmode == BANK && !(ZERO_R0 && wr[k].id.idx == '0))
          mem[wr[k].id.idx] <= wr[k].data;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++)
      rd_data[i] = (ZERO_R0 && rd_idx[i] == '0) ? '0 : mem[rd_idx[i]];
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer + float register file with same-cycle write forwarding and a
// per-register busy scoreboard for long-latency destinations.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NRD = 3,
  parameter int NWR = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NRD-1:0]              rd_fmode,
  input  logic [NRD-1:0][AW-1:0]      rd_reg,
  output logic [NRD-1:0][XLEN-1:0]    rd_data,
  output logic [NRD-1:0]              rd_busy,
  input  logic [NWR-1:0]              wr_en,
  input  logic [NWR-1:0]              wr_fmode,
  input  logic [NWR-1:0][AW-1:0]      wr_reg,
  input  logic [NWR-1:0][XLEN-1:0]    wr_data,
  input  logic                        iss_en,
  input  logic                        iss_fmode,
  input  logic [AW-1:0]               iss_reg,
  output logic                        any_busy
);
  wr_req_t [NWR-1:0]           wr;
  logic [NRD-1:0][XLEN-1:0]    int_rd, fp_rd;
  logic [1:0][NREG-1:0]        busy, busy_nxt;
  reg_id_t                     iss_id;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wr[k].en       = wr_en[k];
      wr[k].id.fmode = wr_fmode[k];
      wr[k].id.idx   = wr_reg[k];
      wr[k].data     = wr_data[k];
    end
  end

  regfile_bank #(.BANK(1'b0), .ZERO_R0(1'b1), .NWR(NWR), .NRD(NRD)) u_int (
    .clk(clk), .rstn(rstn), .wr(wr), .rd_idx(rd_reg), .rd_data(int_rd));
  regfile_bank #(.BANK(1'b1), .ZERO_R0(1'b0), .NWR(NWR), .NRD(NRD)) u_fp (
    .clk(clk), .rstn(rstn), .wr(wr), .rd_idx(rd_reg), .rd_data(fp_rd));

  // A matching write this cycle both supplies the value and hides the busy bit.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      reg_id_t rid;
      logic    hit;
      rid        = '{fmode: rd_fmode[i], idx: rd_reg[i]};
      hit        = 1'b0;
      rd_data[i] = rd_fmode[i] ? fp_rd[i] : int_rd[i];
      for (int k = 0; k < NWR; k++)
        if (wr[k].en && wr[k].id == rid && !is_zero_reg(rid)) begin
          rd_data[i] = wr[k].data;
          hit        = 1'b1;
        end
      rd_busy[i] = busy[rd_fmode[i]][rd_reg[i]] && !hit;
    end
  end

  assign iss_id = '{fmode: iss_fmode, idx: iss_reg};

  // Clears first, then the set, so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) busy_nxt[wr_fmode[k]][wr_reg[k]] = 1'b0;
    if (iss_en && !is_zero_reg(iss_id)) busy_nxt[iss_fmode][iss_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign any_busy = |busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb with an expected-result queue and hand-written corner sequences.
module tb_regfile_sb;
  import regfile_pkg::*;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [NRD-1:0]            rd_fmode;
  logic [NRD-1:0][AW-1:0]    rd_reg;
  logic [NRD-1:0][XLEN-1:0]  rd_data;
  logic [NRD-1:0]            rd_busy;
  logic [NWR-1:0]            wr_en, wr_fmode;
  logic [NWR-1:0][AW-1:0]    wr_reg;
  logic [NWR-1:0][XLEN-1:0]  wr_data;
  logic                      iss_en, iss_fmode;
  logic [AW-1:0]             iss_reg;
  logic                      any_busy;

  regfile_sb #(.NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rstn(rstn), .rd_fmode(rd_fmode), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_fmode(wr_fmode), .wr_reg(wr_reg),
    .wr_data(wr_data), .iss_en(iss_en), .iss_fmode(iss_fmode), .iss_reg(iss_reg),
    .any_busy(any_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic        w0; logic w0f; logic [4:0] w0r; logic [31:0] w0d;
    logic        w1; logic w1f; logic [4:0] w1r; logic [31:0] w1d;
    logic        iss; logic issf; logic [4:0] issr;
    logic        rf; logic [4:0] rr;
    logic [31:0] ed; logic eb; logic ea;
  } vec_t;

  typedef struct {
    logic [NRD-1:0][XLEN-1:0] d;
    logic [NRD-1:0]           b;
    logic                     a;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_fmode = '0; wr_reg = '0; wr_data = '0;
    iss_en = 1'b0; iss_fmode = 1'b0; iss_reg = '0;
  endtask

  // Pop the oldest expectation and compare against the settled outputs.
  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("%s.data%0d", tag, i), rd_data[i], e.d[i]);
      chk($sformatf("%s.busy%0d", tag, i), {31'b0, rd_busy[i]}, {31'b0, e.b[i]});
    end
    chk($sformatf("%s.any", tag), {31'b0, any_busy}, {31'b0, e.a});
  endtask

  function automatic vec_t mk(input logic w0, input logic w0f, input logic [4:0] w0r, input logic [31:0] w0d,
                              input logic w1, input logic w1f, input logic [4:0] w1r, input logic [31:0] w1d,
                              input logic iss, input logic issf, input logic [4:0] issr,
                              input logic rf, input logic [4:0] rr,
                              input logic [31:0] ed, input logic eb, input logic ea);
    vec_t v;
    v.w0 = w0; v.w0f = w0f; v.w0r = w0r; v.w0d = w0d;
    v.w1 = w1; v.w1f = w1f; v.w1r = w1r; v.w1d = w1d;
    v.iss = iss; v.issf = issf; v.issr = issr;
    v.rf = rf; v.rr = rr; v.ed = ed; v.eb = eb; v.ea = ea;
    return v;
  endfunction

  vec_t vt[$];
  exp_t e;

  initial begin
    idle();
    rd_fmode = '0; rd_reg = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    rstn = 1'b1;
    #1;

    //        w0 f  reg data          w1 f  reg data          iss f reg  rf rr  exp_d        b  any
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,5,  32'h0,       0,0)); // reset r5
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,5,  32'h0,       0,0)); // reset f5
    vt.push_back(mk(1,0,0,32'hDEADBEEF, 0,0,0,0,            0,0,0,     0,0,  32'h0,       0,0)); // r0 write same cycle
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,0,  32'h0,       0,0)); // r0 next cycle
    vt.push_back(mk(1,1,0,32'h3F800000, 0,0,0,0,            0,0,0,     1,0,  32'h3F800000,0,0)); // f0 forward
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,0,  32'h3F800000,0,0)); // f0 stored
    vt.push_back(mk(1,1,3,32'h11,       1,1,3,32'h22,       0,0,0,     1,3,  32'h22,      0,0)); // collision fwd
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,3,  32'h22,      0,0)); // collision stored
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,3,  32'h0,       0,0)); // r3 untouched
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            1,1,7,     1,7,  32'h0,       0,0)); // iss f7
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,7,  32'h0,       1,1));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,7,  32'h0,       1,1));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,7,  32'h0,       1,1));
    vt.push_back(mk(0,0,0,0,            1,1,7,32'h40490FDB, 0,0,0,     1,7,  32'h40490FDB,0,1)); // writeback
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,7,  32'h40490FDB,0,0));
    vt.push_back(mk(1,0,9,32'h5,        0,0,0,0,            1,0,9,     0,9,  32'h5,       0,0)); // set+clear r9
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,9,  32'h5,       1,1));
    vt.push_back(mk(0,0,0,0,            1,0,9,32'h7,        0,0,0,     0,9,  32'h7,       0,1));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,9,  32'h7,       0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            1,0,0,     0,0,  32'h0,       0,0)); // iss r0 ignored
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     0,0,  32'h0,       0,0));
    vt.push_back(mk(1,0,6,32'hAA,       1,1,6,32'hBB,       0,0,0,     0,6,  32'hAA,      0,0)); // bank isolation
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,6,  32'hBB,      0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            1,1,0,     1,0,  32'h3F800000,0,0)); // f0 is ordinary
    vt.push_back(mk(0,0,0,0,            0,0,0,0,            0,0,0,     1,0,  32'h3F800000,1,1));
    vt.push_back(mk(1,1,0,32'h1,        0,0,0,0,            0,0,0,     1,0,  32'h1,       0,1));

    foreach (vt[n]) begin
      idle();
      wr_en[0] = vt[n].w0; wr_fmode[0] = vt[n].w0f; wr_reg[0] = vt[n].w0r; wr_data[0] = vt[n].w0d;
      wr_en[1] = vt[n].w1; wr_fmode[1] = vt[n].w1f; wr_reg[1] = vt[n].w1r; wr_data[1] = vt[n].w1d;
      iss_en = vt[n].iss; iss_fmode = vt[n].issf; iss_reg = vt[n].issr;
      for (int i = 0; i < NRD; i++) begin
        rd_fmode[i] = vt[n].rf; rd_reg[i] = vt[n].rr;
        e.d[i] = vt[n].ed; e.b[i] = vt[n].eb;
      end
      e.a = vt[n].ea;
      exp_q.push_back(e);
      #2;
      check_out($sformatf("vec%0d", n));
      @(posedge clk); #1;
    end

    // Independent ports: f3, f7, int r6 in one cycle.
    idle();
    rd_fmode = 3'b011; rd_reg[0] = 5'd3; rd_reg[1] = 5'd7; rd_reg[2] = 5'd6;
    e.d[0] = 32'h22; e.d[1] = 32'h40490FDB; e.d[2] = 32'hAA; e.b = '0; e.a = 1'b0;
    exp_q.push_back(e);
    #2; check_out("ports");
    @(posedge clk); #1;

    // Mid-operation reset drops pending entries and discards reset-cycle writes.
    iss_en = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd4;
    @(posedge clk); #1;
    idle();
    rd_fmode = '0; rd_reg[0] = 5'd4; rd_reg[1] = 5'd2; rd_reg[2] = 5'd8;
    e.d = '0; e.b = 3'b001; e.a = 1'b1;
    exp_q.push_back(e);
    #2; check_out("pre_rst");
    rstn = 1'b0;
    wr_en[0] = 1'b1; wr_reg[0] = 5'd2; wr_data[0] = 32'h55;
    iss_en = 1'b1; iss_reg = 5'd8;
    @(posedge clk); #1;
    rstn = 1'b1; idle();
    e.d = '0; e.b = '0; e.a = 1'b0;
    exp_q.push_back(e);
    #2; check_out("post_rst");
    @(posedge clk); #1;

    // Late writeback after reset is an ordinary write.
    wr_en[1] = 1'b1; wr_reg[1] = 5'd4; wr_data[1] = 32'h99;
    e.d = '0; e.d[0] = 32'h99; e.b = '0; e.a = 1'b0;
    exp_q.push_back(e);
    #2; check_out("late_wb");
    @(posedge clk); #1;
    idle();
    exp_q.push_back(e);
    #2; check_out("late_wb_st");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
